// File: rtl/tmr_scrub_ctrl.sv
// Scrub controller for a triple-redundant register: votes the replicas, confirms a
// disagreement, rewrites the faulty replica(s) during a sequencer grant and verifies.
module tmr_scrub_ctrl #(
   parameter int WIDTH          = 4,
   parameter int CNT_W          = 8,
   parameter int CONFIRM_CYCLES = 1,
   parameter int MAX_RETRY      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scrub_en,
   input  logic [WIDTH-1:0] r0_q,
   input  logic [WIDTH-1:0] r1_q,
   input  logic [WIDTH-1:0] r2_q,
   input  logic             user_idle,
   input  logic             clr_stats,
   output logic [WIDTH-1:0] voted_q,
   output logic             busy,
   output logic             repair_we,
   output logic [2:0]       repair_sel,
   output logic [WIDTH-1:0] repair_data,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fatal
);

   localparam int CNF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   localparam logic [CNF_W-1:0] CNF_INIT = CNF_W'(CONFIRM_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE,
      CONFIRM,
      WAIT_GNT,
      REPAIR,
      VERIFY
   } state_t;

   state_t           state;
   logic [CNF_W-1:0] cnt;
   logic [RTY_W-1:0] retries;
   logic             eq01, eq02, eq12;
   logic             mismatch;
   logic [2:0]       fault_sel;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign eq01     = (r0_q == r1_q);
   assign eq02     = (r0_q == r2_q);
   assign eq12     = (r1_q == r2_q);
   assign mismatch = !(eq01 && eq02 && eq12);
   assign voted_q  = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);

   // Bit i of the select addresses replica i; all-ones means no majority exists.
   always_comb begin
      fault_sel = 3'b000;
      if (eq01 && !eq02)
         fault_sel = 3'b100;
      else if (eq02 && !eq01)
         fault_sel = 3'b010;
      else if (eq12 && !eq01)
         fault_sel = 3'b001;
      else if (!eq01 && !eq02 && !eq12)
         fault_sel = 3'b111;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         retries     <= '0;
         busy        <= 1'b0;
         repair_we   <= 1'b0;
         repair_sel  <= '0;
         repair_data <= '0;
         err_cnt     <= '0;
         fatal       <= 1'b0;
      end else begin
         repair_we <= 1'b0;
         case (state)
            IDLE: begin
               if (scrub_en && mismatch) begin
                  state <= CONFIRM;
                  cnt   <= CNF_INIT;
               end
            end
            CONFIRM: begin
               if (!scrub_en || !mismatch) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state      <= WAIT_GNT;
                  busy       <= 1'b1;
                  repair_sel <= fault_sel;
               end else begin
                  cnt <= cnt - CNF_W'(1);
               end
            end
            WAIT_GNT: begin
               if (!scrub_en) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  retries <= '0;
               end else if (user_idle) begin
                  state       <= REPAIR;
                  repair_we   <= 1'b1;
                  repair_data <= voted_q;
                  err_cnt     <= sat_inc(err_cnt);
                  if (repair_sel == 3'b111)
                     fatal <= 1'b1;
               end
            end
            REPAIR: begin
               state <= VERIFY;
            end
            VERIFY: begin
               // The write landed at the end of REPAIR, so replicas here show the result.
               if (mismatch && (retries < RTY_MAX)) begin
                  state      <= WAIT_GNT;
                  retries    <= retries + RTY_W'(1);
                  repair_sel <= fault_sel;
               end else begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  retries <= '0;
                  if (mismatch)
                     fatal <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         if (clr_stats) begin
            err_cnt <= '0;
            fatal   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: two instances (fast confirm / narrow counter) each driving
// a modelled set of replica registers, checked against an event-level reference.
module tb_tmr_scrub_ctrl;

   logic       clk;
   logic       rst;
   logic       scrub_en;
   logic       user_idle;
   logic       clr_stats;
   logic [3:0] rp [2][3];
   logic       stuck2;

   logic [3:0] vq_a, data_a, vq_b, data_b;
   logic       busy_a, we_a, fatal_a, busy_b, we_b, fatal_b;
   logic [2:0] sel_a, sel_b;
   logic [7:0] err_a;
   logic [1:0] err_b;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int errs [2];
   bit fat [2];
   int emax [2];

   tmr_scrub_ctrl #(.WIDTH(4), .CNT_W(8), .CONFIRM_CYCLES(1), .MAX_RETRY(2)) dut_a (
      .clk(clk), .rst(rst), .scrub_en(scrub_en),
      .r0_q(rp[0][0]), .r1_q(rp[0][1]), .r2_q(rp[0][2]),
      .user_idle(user_idle), .clr_stats(clr_stats),
      .voted_q(vq_a), .busy(busy_a), .repair_we(we_a), .repair_sel(sel_a),
      .repair_data(data_a), .err_cnt(err_a), .fatal(fatal_a)
   );

   tmr_scrub_ctrl #(.WIDTH(4), .CNT_W(2), .CONFIRM_CYCLES(2), .MAX_RETRY(2)) dut_b (
      .clk(clk), .rst(rst), .scrub_en(scrub_en),
      .r0_q(rp[1][0]), .r1_q(rp[1][1]), .r2_q(rp[1][2]),
      .user_idle(user_idle), .clr_stats(clr_stats),
      .voted_q(vq_b), .busy(busy_b), .repair_we(we_b), .repair_sel(sel_b),
      .repair_data(data_b), .err_cnt(err_b), .fatal(fatal_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bitwise majority by counting votes per bit.
   function automatic logic [3:0] maj3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      logic [3:0] m;
      for (int i = 0; i < 4; i++)
         m[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
      return m;
   endfunction

   // Select of the replica that agrees with nobody; all-ones if nobody agrees.
   function automatic logic [2:0] odd_sel(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      logic [3:0] v [3];
      logic [2:0] s;
      int         agree;
      v[0] = a; v[1] = b; v[2] = c;
      s = 3'b000;
      agree = 0;
      for (int i = 0; i < 3; i++)
         for (int j = i + 1; j < 3; j++)
            if (v[i] == v[j]) agree++;
      if (agree == 0) return 3'b111;
      if (agree == 3) return 3'b000;
      for (int i = 0; i < 3; i++)
         if (v[i] != v[(i + 1) % 3] && v[i] != v[(i + 2) % 3]) s[i] = 1'b1;
      return s;
   endfunction

   // One clock: outputs seen now are this cycle's; a write lands before the next edge.
   task automatic cyc();
      logic       wa, wb;
      logic [2:0] sa, sb;
      logic [3:0] da, db;
      wa = we_a; sa = sel_a; da = data_a;
      wb = we_b; sb = sel_b; db = data_b;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (wa && sa[i]) rp[0][i] = da;
         if (wb && sb[i]) rp[1][i] = db;
      end
      if (stuck2) rp[0][2] = 4'hF;
   endtask

   task automatic model_inc(input int env);
      errs[env] = (errs[env] + 1 > emax[env]) ? emax[env] : errs[env] + 1;
   endtask

   task automatic run_event(input int env, input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input int delay);
      int         conf, lat, busy_bad;
      logic [3:0] ev, got_d;
      logic [2:0] es, got_s;
      conf = (env == 0) ? 1 : 2;
      ev = maj3(v0, v1, v2);
      es = odd_sel(v0, v1, v2);
      rp[env][0] = v0; rp[env][1] = v1; rp[env][2] = v2;
      user_idle = 1'b0;
      #1;
      chk("voted_q", 32'(env ? vq_b : vq_a), 32'(ev));
      lat = -1; busy_bad = 0; got_s = 3'b000; got_d = 4'h0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         user_idle = (k >= 1 + conf + delay);
         if ((env ? we_b : we_a) === 1'b1) begin
            lat = k;
            got_s = env ? sel_b : sel_a;
            got_d = env ? data_b : data_a;
         end else begin
            if ((env ? busy_b : busy_a) !== (k >= 1 + conf)) busy_bad++;
            cyc();
         end
      end
      model_inc(env);
      if (es == 3'b111) fat[env] = 1'b1;
      chk("we_latency", 32'(lat), 32'(2 + conf + delay));
      chk("repair_sel", 32'(got_s), 32'(es));
      chk("repair_data", 32'(got_d), 32'(ev));
      chk("busy_profile", 32'(busy_bad), 32'(0));
      cyc();
      chk("busy_verify", 32'(env ? busy_b : busy_a), 32'(1));
      cyc();
      chk("busy_done", 32'(env ? busy_b : busy_a), 32'(0));
      chk("replicas_fixed", {20'h0, rp[env][0], rp[env][1], rp[env][2]}, {20'h0, ev, ev, ev});
      chk("err_cnt", 32'(env ? 8'(err_b) : err_a), 32'(errs[env]));
      chk("fatal", 32'(env ? fatal_b : fatal_a), 32'(fat[env]));
   endtask

   initial begin
      logic [3:0] base, m1, m2, v [3];
      int         nwe, done, seen_busy, seen_we, kind;

      rst = 1'b1; scrub_en = 1'b0; user_idle = 1'b0; clr_stats = 1'b0; stuck2 = 1'b0;
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < 3; i++) rp[e][i] = 4'h0;
         errs[e] = 0; fat[e] = 1'b0;
      end
      emax[0] = 255; emax[1] = 3;
      @(negedge clk);
      cyc(); cyc();
      chk("rst_busy", 32'(busy_a), 32'(0));
      chk("rst_we", 32'(we_a), 32'(0));
      chk("rst_sel", 32'(sel_a), 32'(0));
      chk("rst_data", 32'(data_a), 32'(0));
      chk("rst_err", 32'(err_a), 32'(0));
      chk("rst_fatal", 32'(fatal_a), 32'(0));
      rst = 1'b0; scrub_en = 1'b1; user_idle = 1'b1;
      cyc();

      // Single upset on r2, immediate grant.
      run_event(0, 4'h0, 4'h0, 4'h7, 0);
      // Upset on r0 with the grant withheld three cycles.
      run_event(0, 4'h9, 4'h3, 4'h3, 3);
      // No majority: everything rewritten to the bitwise vote, fatal raised.
      run_event(0, 4'h1, 4'h2, 4'h4, 0);

      // Stuck replica: retries exhausted.
      clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
      errs[0] = 0; fat[0] = 1'b0; errs[1] = 0; fat[1] = 1'b0;
      chk("clr_err", 32'(err_a), 32'(0));
      chk("clr_fatal", 32'(fatal_a), 32'(0));
      stuck2 = 1'b1; rp[0][2] = 4'hF; user_idle = 1'b1;
      nwe = 0; done = 0;
      for (int k = 0; k < 40 && done == 0; k++) begin
         if (fatal_a === 1'b1) done = 1;
         else begin
            if (we_a === 1'b1) nwe++;
            cyc();
         end
      end
      scrub_en = 1'b0; stuck2 = 1'b0; rp[0][2] = 4'h0;
      chk("stuck_fatal_seen", 32'(done), 32'(1));
      chk("stuck_we_pulses", 32'(nwe), 32'(3));
      chk("stuck_err_cnt", 32'(err_a), 32'(3));
      cyc();
      scrub_en = 1'b1; clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
      chk("clr2_err", 32'(err_a), 32'(0));
      chk("clr2_fatal", 32'(fatal_a), 32'(0));

      // clr_stats coinciding with the increment wins.
      rp[0][0] = 4'h3; user_idle = 1'b1;
      cyc(); cyc();
      chk("prio_busy", 32'(busy_a), 32'(1));
      clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
      chk("prio_we", 32'(we_a), 32'(1));
      chk("prio_err", 32'(err_a), 32'(0));
      cyc(); cyc();
      chk("prio_err_after", 32'(err_a), 32'(0));
      chk("prio_fixed", 32'(rp[0][0]), 32'(0));

      // Reset while waiting for the grant drops the write.
      rp[0][1] = 4'h6; user_idle = 1'b0;
      cyc(); cyc();
      chk("rstmid_busy_before", 32'(busy_a), 32'(1));
      rst = 1'b1; cyc();
      chk("rstmid_busy", 32'(busy_a), 32'(0));
      chk("rstmid_we", 32'(we_a), 32'(0));
      chk("rstmid_sel", 32'(sel_a), 32'(0));
      chk("rstmid_data", 32'(data_a), 32'(0));
      chk("rstmid_err", 32'(err_a), 32'(0));
      chk("rstmid_fatal", 32'(fatal_a), 32'(0));
      chk("rstmid_no_write", 32'(rp[0][1]), 32'(6));
      rst = 1'b0; rp[0][1] = 4'h0; user_idle = 1'b1;
      errs[0] = 0; errs[1] = 0; fat[0] = 1'b0; fat[1] = 1'b0;
      cyc();

      // Short glitches on the two-cycle-confirm instance are filtered.
      for (int g = 1; g <= 2; g++) begin
         seen_busy = 0; seen_we = 0;
         rp[1][1] = 4'h5;
         for (int k = 0; k < 10; k++) begin
            if (k == g) rp[1][1] = 4'h0;
            if (busy_b === 1'b1) seen_busy++;
            if (we_b === 1'b1) seen_we++;
            cyc();
         end
         chk("glitch_busy", 32'(seen_busy), 32'(0));
         chk("glitch_we", 32'(seen_we), 32'(0));
         chk("glitch_err", 32'(err_b), 32'(0));
      end

      // Five faults into a 2-bit counter saturate at 3.
      for (int n = 0; n < 5; n++) begin
         base = 4'($urandom_range(0, 15));
         m1 = 4'($urandom_range(1, 15));
         kind = $urandom_range(0, 2);
         for (int i = 0; i < 3; i++) v[i] = base;
         v[kind] = base ^ m1;
         run_event(1, v[0], v[1], v[2], $urandom_range(0, 2));
      end
      chk("sat_err_cnt", 32'(err_b), 32'(3));

      // scrub_en dropped while waiting: abort, no write.
      for (int i = 0; i < 3; i++) rp[0][i] = 4'h0;
      rp[0][1] = 4'h9; user_idle = 1'b0;
      cyc(); cyc();
      scrub_en = 1'b0; cyc();
      chk("abort_busy", 32'(busy_a), 32'(0));
      seen_we = 0;
      for (int k = 0; k < 5; k++) begin
         if (we_a === 1'b1) seen_we++;
         cyc();
      end
      chk("abort_we", 32'(seen_we), 32'(0));
      chk("abort_no_write", 32'(rp[0][1]), 32'(9));
      rp[0][1] = 4'h0; scrub_en = 1'b1;
      cyc();

      // Randomized events on the fast instance.
      for (int n = 0; n < 16; n++) begin
         base = 4'($urandom_range(0, 15));
         m1 = 4'($urandom_range(1, 15));
         m2 = 4'($urandom_range(1, 15));
         if (m2 == m1) m2 = (m1 == 4'hF) ? 4'h1 : (m1 ^ 4'hF);
         kind = $urandom_range(0, 3);
         for (int i = 0; i < 3; i++) v[i] = base;
         if (kind == 3) begin
            v[1] = base ^ m1;
            v[2] = base ^ m2;
         end else begin
            v[kind] = base ^ m1;
         end
         run_event(0, v[0], v[1], v[2], $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
